// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and IF stage output register.
// Handles redirects, stall hold with deferred redirect, and a skid register.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [1:0]  jump_sel,
   input  logic [31:0] br_pc4,
   input  logic [31:0] br_imm,
   input  logic [25:0] j_target,
   input  logic [31:0] rs_val,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc4,
   output logic        if_valid,
   output logic        redirect_pending,
   output logic        pc_misalign
);

   typedef enum logic {
      RUN,
      HOLD
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] pending_pc_q;
   logic [31:0] if_pc4_q;
   logic        if_valid_q;
   logic [31:0] skid_q;
   logic        skid_full_q;
   logic        misalign_q;

   logic [31:0] pc4;
   logic [31:0] tgt;
   logic        redir;
   logic        jr_misalign;

   assign pc4   = pc_q + 32'd4;
   assign redir = (jump_sel != 2'b00);
   assign jr_misalign = (jump_sel == 2'b11) && (rs_val[1:0] != 2'b00);

   // Redirect target selection from the resolving jump/branch.
   always_comb begin
      tgt = pc4;
      case (jump_sel)
         2'b01:   tgt = br_pc4 + {br_imm[29:0], 2'b00};
         2'b10:   tgt = {br_pc4[31:28], j_target, 2'b00};
         2'b11:   tgt = {rs_val[31:2], 2'b00};
         default: tgt = pc4;
      endcase
   end

   // PC, IF output register and RUN/HOLD control.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         pc_q         <= RESET_PC;
         pending_pc_q <= 32'd0;
         if_pc4_q     <= 32'd0;
         if_valid_q   <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         case (state_q)
            RUN: begin
               if (!stall) begin
                  if_pc4_q <= pc4;
                  if (redir) begin
                     pc_q       <= tgt;
                     if_valid_q <= 1'b0;
                     misalign_q <= jr_misalign;
                  end else begin
                     pc_q       <= pc4;
                     if_valid_q <= 1'b1;
                  end
               end else if (redir) begin
                  pending_pc_q <= tgt;
                  state_q      <= HOLD;
                  misalign_q   <= jr_misalign;
               end
            end
            HOLD: begin
               if (!stall) begin
                  pc_q       <= pending_pc_q;
                  if_pc4_q   <= pc4;
                  if_valid_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   // Skid captures the fetched word on the first stalled cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_q      <= 32'd0;
         skid_full_q <= 1'b0;
      end else if (!stall) begin
         skid_full_q <= 1'b0;
      end else if (!skid_full_q) begin
         skid_q      <= imem_rdata;
         skid_full_q <= 1'b1;
      end
   end

   assign imem_addr        = pc_q;
   assign if_instr         = skid_full_q ? skid_q : imem_rdata;
   assign if_pc4           = if_pc4_q;
   assign if_valid         = if_valid_q;
   assign redirect_pending = (state_q == HOLD);
   assign pc_misalign      = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vector bench for pc_fetch_unit.
// Each vector drives inputs, takes one clock, then checks outputs.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [1:0]  jump_sel;
   logic [31:0] br_pc4;
   logic [31:0] br_imm;
   logic [25:0] j_target;
   logic [31:0] rs_val;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_instr;
   logic [31:0] if_pc4;
   logic        if_valid;
   logic        redirect_pending;
   logic        pc_misalign;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .jump_sel         (jump_sel),
      .br_pc4           (br_pc4),
      .br_imm           (br_imm),
      .j_target         (j_target),
      .rs_val           (rs_val),
      .imem_addr        (imem_addr),
      .imem_rdata       (imem_rdata),
      .if_instr         (if_instr),
      .if_pc4           (if_pc4),
      .if_valid         (if_valid),
      .redirect_pending (redirect_pending),
      .pc_misalign      (pc_misalign)
   );

   typedef struct {
      logic        rst;
      logic        stall;
      logic [1:0]  js;
      logic [31:0] bpc4;
      logic [31:0] bimm;
      logic [25:0] jt;
      logic [31:0] rs;
      logic [31:0] rdata;
      logic [31:0] e_addr;
      logic        e_valid;
      logic        c_pc4;
      logic [31:0] e_pc4;
      logic        e_pend;
      logic        e_mis;
      logic [31:0] e_instr;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(
      input logic        r,
      input logic        s,
      input logic [1:0]  js,
      input logic [31:0] bpc4,
      input logic [31:0] bimm,
      input logic [25:0] jt,
      input logic [31:0] rs,
      input logic [31:0] rdata,
      input logic [31:0] e_addr,
      input logic        e_valid,
      input logic        c_pc4,
      input logic [31:0] e_pc4,
      input logic        e_pend,
      input logic        e_mis,
      input logic [31:0] e_instr
   );
      vec_t v;
      v.rst = r; v.stall = s; v.js = js;
      v.bpc4 = bpc4; v.bimm = bimm; v.jt = jt;
      v.rs = rs; v.rdata = rdata;
      v.e_addr = e_addr; v.e_valid = e_valid;
      v.c_pc4 = c_pc4; v.e_pc4 = e_pc4;
      v.e_pend = e_pend; v.e_mis = e_mis;
      v.e_instr = e_instr;
      return v;
   endfunction

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL v%0d %s got %h want %h", idx, name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      rst        = v.rst;
      stall      = v.stall;
      jump_sel   = v.js;
      br_pc4     = v.bpc4;
      br_imm     = v.bimm;
      j_target   = v.jt;
      rs_val     = v.rs;
      imem_rdata = v.rdata;
      @(posedge clk);
      #1;
      chk("imem_addr", idx, imem_addr, v.e_addr);
      chk("if_valid", idx, {31'd0, if_valid}, {31'd0, v.e_valid});
      if (v.c_pc4)
         chk("if_pc4", idx, if_pc4, v.e_pc4);
      chk("redirect_pending", idx,
          {31'd0, redirect_pending}, {31'd0, v.e_pend});
      chk("pc_misalign", idx,
          {31'd0, pc_misalign}, {31'd0, v.e_mis});
      chk("if_instr", idx, if_instr, v.e_instr);
   endtask

   localparam logic [31:0] Z = 32'd0;
   localparam logic [31:0] M2 = 32'hFFFF_FFFE;

   initial begin
      rst = 1'b1; stall = 1'b0; jump_sel = 2'b00;
      br_pc4 = Z; br_imm = Z; j_target = 26'd0;
      rs_val = Z; imem_rdata = Z;

      // reset and sequential fetch
      tv.push_back(mk(1,0,2'b00,Z,Z,0,Z,32'h11,
                      Z,0,1,Z,0,0,32'h11));
      tv.push_back(mk(0,0,2'b00,Z,Z,0,Z,32'h12,
                      32'h4,1,1,32'h4,0,0,32'h12));
      tv.push_back(mk(0,0,2'b00,Z,Z,0,Z,32'h13,
                      32'h8,1,1,32'h8,0,0,32'h13));
      tv.push_back(mk(0,0,2'b00,Z,Z,0,Z,32'h14,
                      32'hC,1,1,32'hC,0,0,32'h14));
      // JR to 0x100, then branch back by 2 words
      tv.push_back(mk(0,0,2'b11,Z,Z,0,32'h100,32'h15,
                      32'h100,0,1,32'h10,0,0,32'h15));
      tv.push_back(mk(0,0,2'b01,32'h104,M2,0,Z,32'h16,
                      32'h0FC,0,1,32'h104,0,0,32'h16));
      tv.push_back(mk(0,0,2'b00,Z,Z,0,Z,32'h17,
                      32'h100,1,1,32'h100,0,0,32'h17));
      // J and misaligned JR
      tv.push_back(mk(0,0,2'b10,32'h3000_0010,Z,26'h40,Z,32'h18,
                      32'h3000_0100,0,1,32'h104,0,0,32'h18));
      tv.push_back(mk(0,0,2'b11,Z,Z,0,32'h2003,32'h19,
                      32'h2000,0,1,32'h3000_0104,0,1,32'h19));
      tv.push_back(mk(0,0,2'b00,Z,Z,0,Z,32'h1A,
                      32'h2004,1,1,32'h2004,0,0,32'h1A));
      // stall with branch to 0x200; HOLD ignores jump_sel
      tv.push_back(mk(0,1,2'b01,32'h100,32'h40,0,Z,32'hAAAA_0001,
                      32'h2004,1,1,32'h2004,1,0,32'hAAAA_0001));
      tv.push_back(mk(0,1,2'b01,32'h100,32'h40,0,Z,32'hBBBB_0002,
                      32'h2004,1,1,32'h2004,1,0,32'hAAAA_0001));
      tv.push_back(mk(0,1,2'b10,Z,Z,26'h3FF,Z,32'hCCCC_0003,
                      32'h2004,1,1,32'h2004,1,0,32'hAAAA_0001));
      tv.push_back(mk(0,0,2'b00,Z,Z,0,Z,32'hDDDD_0004,
                      32'h200,0,0,Z,0,0,32'hDDDD_0004));
      tv.push_back(mk(0,0,2'b00,Z,Z,0,Z,32'h1B,
                      32'h204,1,1,32'h204,0,0,32'h1B));
      // reset while in HOLD
      tv.push_back(mk(0,1,2'b01,32'h100,32'h40,0,Z,32'h1C,
                      32'h204,1,1,32'h204,1,0,32'h1C));
      tv.push_back(mk(1,1,2'b01,32'h100,32'h40,0,Z,32'h1D,
                      Z,0,1,Z,0,0,32'h1D));
      tv.push_back(mk(0,0,2'b00,Z,Z,0,Z,32'h1E,
                      32'h4,1,1,32'h4,0,0,32'h1E));
      // PC+4 wrap
      tv.push_back(mk(0,0,2'b11,Z,Z,0,32'hFFFF_FFFC,32'h1F,
                      32'hFFFF_FFFC,0,1,32'h8,0,0,32'h1F));
      tv.push_back(mk(0,0,2'b00,Z,Z,0,Z,32'h20,
                      Z,1,1,Z,0,0,32'h20));
      // misaligned JR latched during stall
      tv.push_back(mk(0,1,2'b11,Z,Z,0,32'h301,32'h21,
                      Z,1,1,Z,1,1,32'h21));
      tv.push_back(mk(0,1,2'b00,Z,Z,0,Z,32'h22,
                      Z,1,1,Z,1,0,32'h21));
      tv.push_back(mk(0,0,2'b00,Z,Z,0,Z,32'h23,
                      32'h300,0,0,Z,0,0,32'h23));

      @(negedge clk);
      foreach (tv[i]) apply(tv[i], i);

      // plain stall with no redirect: hold and skid only
      apply(mk(0,0,2'b00,Z,Z,0,Z,32'h24,
               32'h304,1,1,32'h304,0,0,32'h24), 100);
      apply(mk(0,1,2'b00,Z,Z,0,Z,32'h5555,
               32'h304,1,1,32'h304,0,0,32'h5555), 101);
      apply(mk(0,1,2'b00,Z,Z,0,Z,32'h6666,
               32'h304,1,1,32'h304,0,0,32'h5555), 102);
      apply(mk(0,0,2'b00,Z,Z,0,Z,32'h7777,
               32'h308,1,1,32'h308,0,0,32'h7777), 103);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have one clock and reset, synchronous active-high, with ports in this order:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-003 The block SHALL have these further ports:
- stall  in  1  hold PC and the IF output stage.
- jump_sel  in  2  next-PC select from jump/branch logic: 00 PC+4, 01 branch, 10 jump, 11 register.
- br_pc4  in  32  PC+4 of the resolving jump/branch instruction.
- br_imm  in  32  sign-extended 16-bit branch offset, in words.
- j_target  in  26  J/JAL target field.
- rs_val  in  32  RS register value for JR/JALR.
- imem_addr  out  32  instruction memory address; synchronous-read memory, data valid the next cycle.
- imem_rdata  in  32  instruction memory read data.
- if_instr  out  32  fetched instruction to decode.
- if_pc4  out  32  PC+4 of if_instr.
- if_valid  out  1  if_instr/if_pc4 hold a correct-path instruction.
- redirect_pending  out  1  a redirect arrived during stall and has not yet been applied.
- pc_misalign  out  1  one-cycle pulse when a JR/JALR target had rs_val[1:0] != 0.

Function
REQ-004 Redirect target SHALL be computed from jump_sel, with all arithmetic modulo 2^32:
- 01: br_pc4 + (br_imm << 2).
- 10: {br_pc4[31:28], j_target, 2'b00}.
- 11: {rs_val[31:2], 2'b00}.
REQ-005 imem_addr SHALL equal the PC register combinationally.
REQ-006 The block SHALL have two states, RUN and HOLD. In RUN with stall=0:
- PC <= redirect target if jump_sel != 00, else PC+4.
- if_pc4 <= PC+4.
REQ-007 A redirect SHALL kill the wrong-path fetch in flight: on the cycle after a redirect is applied, if_valid = 0. Otherwise if_valid = 1 on the cycle after each non-stalled fetch.
REQ-008 In RUN with stall=1 and jump_sel != 00, the block SHALL latch the target into pending_pc and go to HOLD. redirect_pending SHALL be 1 while in HOLD.
REQ-009 In HOLD, jump_sel SHALL be ignored. The first cycle with stall=0 SHALL load PC <= pending_pc, force if_valid = 0 on the next cycle, and return to RUN.
REQ-010 While stall=1, the PC, if_pc4 and if_valid SHALL hold their values.
REQ-011 On the first stalled cycle, imem_rdata SHALL be captured into a skid register:
- While the skid is full, if_instr = skid value; otherwise if_instr = imem_rdata.
- The skid SHALL be emptied on the first cycle with stall=0.
REQ-012 A redirect with stall=0 SHALL take effect in the same cycle. There is no branch delay slot.
REQ-013 pc_misalign SHALL pulse for one cycle when a jump_sel=11 redirect is applied or latched with rs_val[1:0] != 0.
REQ-014 PC+4 wrap from 32'hFFFF_FFFC to 32'h0000_0000 SHALL be silent.

Reset
REQ-015 While rst=1, the block SHALL hold these values, with rst taking priority over stall and jump_sel:
- PC = RESET_PC, pending_pc = 0, state = RUN, skid empty.
- if_valid = 0, if_pc4 = 0, redirect_pending = 0, pc_misalign = 0.
REQ-016 On the first cycle after rst falls, imem_addr SHALL be RESET_PC, and if_valid SHALL rise one cycle later.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Sequential: reset, then 4 cycles with no stall and jump_sel=00 -> imem_addr 0,4,8,C; if_valid 0,1,1,1; if_pc4 lags imem_addr by one cycle.
- Branch: PC=0x100, jump_sel=01, br_pc4=0x104, br_imm=32'hFFFF_FFFE -> next imem_addr 0x0FC; if_valid=0 for one cycle.
- Jump and JR: jump_sel=10, br_pc4=0x3000_0010, j_target=26'h000_0040 -> imem_addr 0x3000_0100. jump_sel=11, rs_val=0x0000_2003 -> imem_addr 0x2000, pc_misalign pulses once.
- Stall plus redirect: stall=1 with jump_sel=01 (target 0x200) for 3 cycles -> PC held, redirect_pending=1, if_instr stable at the skid value. Stall drops -> imem_addr 0x200, redirect_pending=0, if_valid=0 for one cycle.
- Reset in HOLD: rst=1 while redirect_pending=1 -> next cycle imem_addr=RESET_PC, redirect_pending=0, if_valid=0.
- Wrap: PC=32'hFFFF_FFFC with jump_sel=00 -> next imem_addr 32'h0000_0000.
